// File: rtl/rx_packet_fsm_if.sv
// Byte-level receive bus between the USB deserialiser (master) and the packet decoder (slave).
interface rx_packet_fsm_if #(
  parameter int MAX_DATA_BYTES = 64
);
  localparam int CW = $clog2(MAX_DATA_BYTES + 1);

  logic          sync_detected;
  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          eop;
  logic          bit_error;
  logic          crc5_ok;
  logic          crc16_ok;
  logic [6:0]    dev_addr;

  logic          crc_clear;
  logic [2:0]    rx_packet;
  logic [3:0]    rx_pid;
  logic [6:0]    token_addr;
  logic [3:0]    token_endp;
  logic [7:0]    rx_data;
  logic          store_rx_data;
  logic [CW-1:0] data_count;
  logic          packet_done;
  logic          packet_error;

  modport master (
    output sync_detected, byte_valid, rx_byte, eop, bit_error, crc5_ok, crc16_ok, dev_addr,
    input  crc_clear, rx_packet, rx_pid, token_addr, token_endp, rx_data, store_rx_data,
           data_count, packet_done, packet_error
  );

  modport slave (
    input  sync_detected, byte_valid, rx_byte, eop, bit_error, crc5_ok, crc16_ok, dev_addr,
    output crc_clear, rx_packet, rx_pid, token_addr, token_endp, rx_data, store_rx_data,
           data_count, packet_done, packet_error
  );
endinterface

// File: rtl/rx_packet_fsm.sv
// USB receive packet decoder: classifies PIDs, captures token fields and streams DATA
// payload while withholding the trailing CRC16 bytes.
module rx_packet_fsm #(
  parameter int MAX_DATA_BYTES = 64,
  parameter bit ADDR_CHECK_EN  = 1'b1
) (
  input  logic           clk,
  input  logic           n_rst,
  rx_packet_fsm_if.slave bus
);
  localparam int CW = $clog2(MAX_DATA_BYTES + 1);

  localparam logic [2:0] PKT_NONE  = 3'b000;
  localparam logic [2:0] PKT_OUT   = 3'b001;
  localparam logic [2:0] PKT_IN    = 3'b010;
  localparam logic [2:0] PKT_SETUP = 3'b011;
  localparam logic [2:0] PKT_DATA0 = 3'b100;
  localparam logic [2:0] PKT_DATA1 = 3'b101;
  localparam logic [2:0] PKT_HS    = 3'b110;
  localparam logic [2:0] PKT_ERR   = 3'b111;

  typedef enum logic [2:0] {IDLE, PID, TOK1, TOK2, TOK_EOP, HS_EOP, DATA, ERR} state_t;

  state_t        state_q, state_d;
  logic [2:0]    kind_q, kind_d;
  logic [6:0]    addr_tmp_q, addr_tmp_d;
  logic [3:0]    endp_tmp_q, endp_tmp_d;
  logic [7:0]    hold0_q, hold0_d, hold1_q, hold1_d;
  logic [1:0]    pipe_cnt_q, pipe_cnt_d;
  logic          crc_clear_q, crc_clear_d;
  logic [2:0]    rx_packet_q, rx_packet_d;
  logic [3:0]    rx_pid_q, rx_pid_d;
  logic [6:0]    token_addr_q, token_addr_d;
  logic [3:0]    token_endp_q, token_endp_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          store_q, store_d;
  logic [CW-1:0] data_count_q, data_count_d;
  logic          done_q, done_d, perr_q, perr_d;
  logic          eop_fail;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      kind_q       <= '0;
      addr_tmp_q   <= '0;
      endp_tmp_q   <= '0;
      hold0_q      <= '0;
      hold1_q      <= '0;
      pipe_cnt_q   <= '0;
      crc_clear_q  <= 1'b0;
      rx_packet_q  <= PKT_NONE;
      rx_pid_q     <= '0;
      token_addr_q <= '0;
      token_endp_q <= '0;
      rx_data_q    <= '0;
      store_q      <= 1'b0;
      data_count_q <= '0;
      done_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      addr_tmp_q   <= addr_tmp_d;
      endp_tmp_q   <= endp_tmp_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
      pipe_cnt_q   <= pipe_cnt_d;
      crc_clear_q  <= crc_clear_d;
      rx_packet_q  <= rx_packet_d;
      rx_pid_q     <= rx_pid_d;
      token_addr_q <= token_addr_d;
      token_endp_q <= token_endp_d;
      rx_data_q    <= rx_data_d;
      store_q      <= store_d;
      data_count_q <= data_count_d;
      done_q       <= done_d;
      perr_q       <= perr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    addr_tmp_d   = addr_tmp_q;
    endp_tmp_d   = endp_tmp_q;
    hold0_d      = hold0_q;
    hold1_d      = hold1_q;
    pipe_cnt_d   = pipe_cnt_q;
    crc_clear_d  = 1'b0;
    rx_packet_d  = rx_packet_q;
    rx_pid_d     = rx_pid_q;
    token_addr_d = token_addr_q;
    token_endp_d = token_endp_q;
    rx_data_d    = rx_data_q;
    store_d      = 1'b0;
    data_count_d = data_count_q;
    done_d       = 1'b0;
    perr_d       = 1'b0;
    eop_fail     = 1'b0;

    if (bus.sync_detected) begin
      crc_clear_d  = 1'b1;
      data_count_d = '0;
      rx_packet_d  = PKT_NONE;
      pipe_cnt_d   = '0;
      state_d      = PID;
    end else if (state_q == IDLE) begin
      state_d = IDLE;
    end else if (bus.bit_error && state_q != ERR) begin
      state_d = ERR;
    end else begin
      case (state_q)
        PID: begin
          if (bus.eop) begin
            eop_fail = 1'b1;
          end else if (bus.byte_valid) begin
            if (bus.rx_byte[7:4] != ~bus.rx_byte[3:0]) begin
              state_d = ERR;
            end else begin
              rx_pid_d = bus.rx_byte[3:0];
              case (bus.rx_byte)
                8'hE1:   begin kind_d = PKT_OUT;   state_d = TOK1; end
                8'h69:   begin kind_d = PKT_IN;    state_d = TOK1; end
                8'h2D:   begin kind_d = PKT_SETUP; state_d = TOK1; end
                8'hC3:   begin kind_d = PKT_DATA0; state_d = DATA; end
                8'h4B:   begin kind_d = PKT_DATA1; state_d = DATA; end
                8'hD2, 8'h5A, 8'h1E: state_d = HS_EOP;
                default: state_d = ERR;
              endcase
            end
          end
        end
        TOK1: begin
          if (bus.eop) begin
            eop_fail = 1'b1;
          end else if (bus.byte_valid) begin
            addr_tmp_d    = bus.rx_byte[6:0];
            endp_tmp_d[0] = bus.rx_byte[7];
            state_d       = TOK2;
          end
        end
        TOK2: begin
          if (bus.eop) begin
            eop_fail = 1'b1;
          end else if (bus.byte_valid) begin
            endp_tmp_d[3:1] = bus.rx_byte[2:0];
            state_d         = TOK_EOP;
          end
        end
        TOK_EOP: begin
          if (bus.eop) begin
            state_d = IDLE;
            if (!bus.crc5_ok) begin
              eop_fail = 1'b1;
            end else if (!ADDR_CHECK_EN || addr_tmp_q == bus.dev_addr) begin
              token_addr_d = addr_tmp_q;
              token_endp_d = endp_tmp_q;
              rx_packet_d  = kind_q;
              done_d       = 1'b1;
            end
          end else if (bus.byte_valid) begin
            state_d = ERR;
          end
        end
        HS_EOP: begin
          if (bus.eop) begin
            rx_packet_d = PKT_HS;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (bus.byte_valid) begin
            state_d = ERR;
          end
        end
        DATA: begin
          if (bus.eop) begin
            state_d = IDLE;
            if (pipe_cnt_q == 2'd2 && bus.crc16_ok) begin
              rx_packet_d = kind_q;
              done_d      = 1'b1;
            end else begin
              eop_fail = 1'b1;
            end
          end else if (bus.byte_valid) begin
            // The last two bytes seen are always held back: they may be the CRC16.
            if (pipe_cnt_q != 2'd2) begin
              if (pipe_cnt_q == 2'd0) hold0_d = bus.rx_byte;
              else                    hold1_d = bus.rx_byte;
              pipe_cnt_d = pipe_cnt_q + 2'd1;
            end else if (data_count_q == CW'(MAX_DATA_BYTES)) begin
              state_d = ERR;
            end else begin
              rx_data_d    = hold0_q;
              store_d      = 1'b1;
              data_count_d = data_count_q + CW'(1);
              hold0_d      = hold1_q;
              hold1_d      = bus.rx_byte;
            end
          end
        end
        ERR: begin
          if (bus.eop) eop_fail = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (eop_fail) begin
        rx_packet_d = PKT_ERR;
        perr_d      = 1'b1;
        state_d     = IDLE;
      end
    end
  end

  assign bus.crc_clear     = crc_clear_q;
  assign bus.rx_packet     = rx_packet_q;
  assign bus.rx_pid        = rx_pid_q;
  assign bus.token_addr    = token_addr_q;
  assign bus.token_endp    = token_endp_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.store_rx_data = store_q;
  assign bus.data_count    = data_count_q;
  assign bus.packet_done   = done_q;
  assign bus.packet_error  = perr_q;
endmodule

// File: tb/tb_rx_packet_fsm.sv
// Bench for rx_packet_fsm: directed packets with literal expectations plus random traffic,
// all checked every cycle against a byte-history reference model.
module tb_rx_packet_fsm;
  localparam int MAXB = 4;
  localparam int CW   = $clog2(MAXB + 1);

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  rx_packet_fsm_if #(.MAX_DATA_BYTES(MAXB)) bus ();
  rx_packet_fsm #(.MAX_DATA_BYTES(MAXB), .ADDR_CHECK_EN(1'b1)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: keeps the bytes of the current packet and derives outputs from them.
  logic [7:0]    q[$];
  bit            active, bad;
  logic          e_clr, e_store, e_done, e_err;
  logic [2:0]    e_pkt;
  logic [3:0]    e_pid, e_tendp;
  logic [6:0]    e_taddr;
  logic [7:0]    e_rx;
  logic [CW-1:0] e_cnt;

  int n_store = 0, n_done = 0, n_perr = 0;
  logic [7:0] got[$];

  function automatic int pid_class(input logic [7:0] p);
    case (p)
      8'hE1, 8'h69, 8'h2D: return 1;
      8'hC3, 8'h4B:        return 2;
      8'hD2, 8'h5A, 8'h1E: return 3;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [2:0] pid_code(input logic [7:0] p);
    case (p)
      8'hE1: return 3'd1;
      8'h69: return 3'd2;
      8'h2D: return 3'd3;
      8'hC3: return 3'd4;
      8'h4B: return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  task automatic mdl_reset();
    q.delete(); active = 0; bad = 0;
    e_clr = 0; e_store = 0; e_done = 0; e_err = 0; e_pkt = 0; e_pid = 0;
    e_tendp = 0; e_taddr = 0; e_rx = 0; e_cnt = 0;
  endtask

  task automatic mdl_byte(input logic [7:0] b);
    int n, m;
    logic [3:0] hi, lo;
    n = q.size();
    if (n == 0) begin
      hi = b[7:4]; lo = b[3:0];
      if ((hi ^ lo) != 4'hF) bad = 1;
      else begin
        e_pid = lo;
        if (pid_class(b) == 0) bad = 1; else q.push_back(b);
      end
    end else begin
      case (pid_class(q[0]))
        1: if (n >= 3) bad = 1; else q.push_back(b);
        2: begin
          q.push_back(b);
          m = q.size();
          if (m >= 4) begin
            if (int'(e_cnt) == MAXB) bad = 1;
            else begin e_rx = q[m-3]; e_store = 1; e_cnt = e_cnt + 1'b1; end
          end
        end
        default: bad = 1;
      endcase
    end
  endtask

  task automatic mdl_eop();
    int n;
    bit fail;
    logic [7:0] b1, b2;
    n = q.size(); fail = 0;
    if (n == 0) fail = 1;
    else begin
      case (pid_class(q[0]))
        1: begin
          if (n < 3 || !bus.crc5_ok) fail = 1;
          else begin
            b1 = q[1]; b2 = q[2];
            if (b1[6:0] == bus.dev_addr) begin
              e_taddr = b1[6:0]; e_tendp = {b2[2:0], b1[7]};
              e_pkt = pid_code(q[0]); e_done = 1;
            end
          end
        end
        2: if (n >= 3 && bus.crc16_ok) begin e_pkt = pid_code(q[0]); e_done = 1; end
           else fail = 1;
        default: begin e_pkt = 3'd6; e_done = 1; end
      endcase
    end
    if (fail) begin e_pkt = 3'd7; e_err = 1; end
    active = 0;
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) mdl_reset();
      else begin
        e_clr = 0; e_store = 0; e_done = 0; e_err = 0;
        if (bus.sync_detected) begin
          e_clr = 1; e_cnt = 0; e_pkt = 0; q.delete(); active = 1; bad = 0;
        end else if (active && !bad) begin
          if (bus.bit_error)       bad = 1;
          else if (bus.eop)        mdl_eop();
          else if (bus.byte_valid) mdl_byte(bus.rx_byte);
        end else if (active && bus.eop) begin
          e_pkt = 3'd7; e_err = 1; active = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if ({bus.crc_clear, bus.rx_packet, bus.rx_pid, bus.token_addr, bus.token_endp, bus.rx_data,
           bus.store_rx_data, bus.data_count, bus.packet_done, bus.packet_error} !==
          {e_clr, e_pkt, e_pid, e_taddr, e_tendp, e_rx, e_store, e_cnt, e_done, e_err}) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got clr=%b pkt=%0d pid=%h ta=%h te=%h rx=%h st=%b cnt=%0d dn=%b er=%b required clr=%b pkt=%0d pid=%h ta=%h te=%h rx=%h st=%b cnt=%0d dn=%b er=%b",
                 $time, bus.crc_clear, bus.rx_packet, bus.rx_pid, bus.token_addr, bus.token_endp,
                 bus.rx_data, bus.store_rx_data, bus.data_count, bus.packet_done, bus.packet_error,
                 e_clr, e_pkt, e_pid, e_taddr, e_tendp, e_rx, e_store, e_cnt, e_done, e_err);
      end
      if (bus.store_rx_data === 1'b1) begin n_store++; got.push_back(bus.rx_data); end
      if (bus.packet_done === 1'b1)  n_done++;
      if (bus.packet_error === 1'b1) n_perr++;
    end
  end

  task automatic check(input string name, input int actual, input int required);
    tests++;
    if (actual != required) begin
      fails++;
      $display("FAIL %s got %0d required %0d", name, actual, required);
    end
  endtask

  task automatic drive(input logic s, input logic bv, input logic [7:0] b, input logic e, input logic be);
    bus.sync_detected = s; bus.byte_valid = bv; bus.rx_byte = b; bus.eop = e; bus.bit_error = be;
    @(posedge clk); #1;
    bus.sync_detected = 1'b0; bus.byte_valid = 1'b0; bus.eop = 1'b0; bus.bit_error = 1'b0;
  endtask

  task automatic send_sync();                drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); endtask
  task automatic send_byte(input logic [7:0] b); drive(1'b0, 1'b1, b, 1'b0, 1'b0); endtask
  task automatic send_berr();                drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); endtask
  task automatic gap(input int n);           repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endtask
  task automatic send_eop(input logic c5, input logic c16);
    bus.crc5_ok = c5; bus.crc16_ok = c16;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  logic [7:0] pid_tab [9];
  int s0, d0, e0, g0, sel, nb, cls;
  logic [7:0] pid, b;

  initial begin
    pid_tab = '{8'hE1, 8'h69, 8'h2D, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'h00};
    bus.sync_detected = 1'b0; bus.byte_valid = 1'b0; bus.rx_byte = 8'h00; bus.eop = 1'b0;
    bus.bit_error = 1'b0; bus.crc5_ok = 1'b1; bus.crc16_ok = 1'b1; bus.dev_addr = 7'h05;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pkt", int'(bus.rx_packet), 0);
    check("rst_cnt", int'(bus.data_count), 0);
    n_rst = 1'b1;
    gap(2);

    // OUT token to address 5; endpoint bits come from byte1[7] and byte2[2:0].
    d0 = n_done;
    send_sync(); send_byte(8'hE1); send_byte(8'h05); send_byte(8'h10); send_eop(1'b1, 1'b1); gap(1);
    check("tok_pkt", int'(bus.rx_packet), 1);
    check("tok_addr", int'(bus.token_addr), 5);
    check("tok_endp0", int'(bus.token_endp), 0);
    check("tok_done", n_done - d0, 1);
    send_sync(); send_byte(8'h2D); send_byte(8'h05); send_byte(8'h01); send_eop(1'b1, 1'b1); gap(1);
    check("tok_endp2", int'(bus.token_endp), 2);
    check("setup_pkt", int'(bus.rx_packet), 3);

    // Token for another device is dropped silently.
    d0 = n_done;
    send_sync(); send_byte(8'h69); send_byte(8'h07); send_byte(8'h00); send_eop(1'b1, 1'b1); gap(1);
    check("miss_pkt", int'(bus.rx_packet), 0);
    check("miss_addr", int'(bus.token_addr), 5);
    check("miss_done", n_done - d0, 0);

    // DATA0 with three payload bytes.
    s0 = n_store; d0 = n_done; g0 = got.size();
    send_sync(); send_byte(8'hC3);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'h11); send_byte(8'h22);
    send_eop(1'b0, 1'b1); gap(1);
    check("d0_stores", n_store - s0, 3);
    check("d0_b0", int'(got[g0]), 'hAA);
    check("d0_b2", int'(got[g0+2]), 'hCC);
    check("d0_cnt", int'(bus.data_count), 3);
    check("d0_pkt", int'(bus.rx_packet), 4);
    check("d0_done", n_done - d0, 1);

    // DATA1 zero-length with bad CRC16.
    s0 = n_store; e0 = n_perr;
    send_sync(); send_byte(8'h4B); send_byte(8'hC1); send_byte(8'hC2); send_eop(1'b1, 1'b0); gap(1);
    check("d1bad_stores", n_store - s0, 0);
    check("d1bad_pkt", int'(bus.rx_packet), 7);
    check("d1bad_err", n_perr - e0, 1);

    // Payload over MAX_DATA_BYTES: four stores, then error at eop.
    s0 = n_store; e0 = n_perr;
    send_sync(); send_byte(8'hC3);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i));
    send_eop(1'b1, 1'b1); gap(1);
    check("ovf_stores", n_store - s0, 4);
    check("ovf_pkt", int'(bus.rx_packet), 7);
    check("ovf_err", n_perr - e0, 1);

    // Invalid PID, bit_error in DATA, and a restart by sync mid-packet.
    s0 = n_store; e0 = n_perr;
    send_sync(); send_byte(8'hE2); send_byte(8'h44); send_eop(1'b1, 1'b1); gap(1);
    check("badpid_err", n_perr - e0, 1);
    send_sync(); send_byte(8'hC3); send_byte(8'hAA); send_berr(); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'hDD); send_eop(1'b1, 1'b1); gap(1);
    check("berr_err", n_perr - e0, 2);
    check("berr_stores", n_store - s0, 0);
    d0 = n_done;
    send_sync(); send_byte(8'hC3); send_byte(8'hAA); send_sync();
    check("resync_clr", int'(bus.crc_clear), 1);
    send_byte(8'hD2); send_eop(1'b1, 1'b1); gap(1);
    check("resync_pkt", int'(bus.rx_packet), 6);
    check("resync_pulses", (n_done - d0) + (n_perr - e0), 3);

    // Asynchronous reset in the middle of a DATA packet.
    s0 = n_store;
    send_sync(); send_byte(8'hC3);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i));
    gap(1);
    check("mid_stores", n_store - s0, 2);
    check("mid_cnt", int'(bus.data_count), 2);
    #2 n_rst = 1'b0;
    #1;
    check("arst_pkt", int'(bus.rx_packet), 0);
    check("arst_cnt", int'(bus.data_count), 0);
    check("arst_rx", int'(bus.rx_data), 0);
    check("arst_pid", int'(bus.rx_pid), 0);
    check("arst_tok", int'({bus.token_addr, bus.token_endp}), 0);
    @(posedge clk); #1 n_rst = 1'b1;
    gap(1);
    send_sync(); send_byte(8'hD2); send_eop(1'b1, 1'b1); gap(1);
    check("post_rst_ack", int'(bus.rx_packet), 6);

    // Random traffic checked by the model.
    for (int p = 0; p < 300; p++) begin
      sel = $urandom_range(0, 8);
      pid = pid_tab[sel];
      if (sel == 8) pid = 8'($urandom);
      cls = pid_class(pid);
      case (cls)
        1:       nb = 2;
        2:       nb = $urandom_range(2, 7);
        3:       nb = 0;
        default: nb = $urandom_range(0, 2);
      endcase
      if ($urandom_range(0, 9) == 0) nb = nb + 1;
      else if (nb > 0 && $urandom_range(0, 9) == 0) nb = nb - 1;
      send_sync(); gap($urandom_range(0, 1));
      send_byte(pid);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        if (cls == 1 && i == 0 && $urandom_range(0, 3) != 0) b = {b[7], 7'h05};
        if ($urandom_range(0, 39) == 0) send_berr();
        if ($urandom_range(0, 49) == 0) begin send_sync(); send_byte(8'h5A); end
        gap($urandom_range(0, 1));
        send_byte(b);
      end
      gap($urandom_range(0, 1));
      send_eop(logic'($urandom_range(0, 5) != 0), logic'($urandom_range(0, 5) != 0));
      gap($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin send_byte(8'($urandom)); gap(1); end
      if ($urandom_range(0, 15) == 0) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    gap(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
